// File: rtl/dma_dev_port_pkg.sv
// dma_dev_port_pkg: shared state encoding and width defaults for the DMA device port
package dma_dev_port_pkg;
  localparam int ADD_LEN_DEF = 16;
  localparam int DATA_LEN_DEF = 16;
  localparam int BUF_AW_DEF = 4;
  typedef enum logic [2:0] {IDLE, FILL, XFER_WR, XFER_RD, DRAIN} state_t;
endpackage

// File: rtl/dma_dev_port_if.sv
// dma_dev_port_if: request/ack bus between a device endpoint and the DMA controller
interface dma_dev_port_if import dma_dev_port_pkg::*; #(
  parameter int ADD_LEN = ADD_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
) ();
  logic                rqst;
  logic                rd_wr;
  logic [ADD_LEN:0]    start_addr;
  logic [ADD_LEN-1:0]  num_words;
  logic                dev_ack;
  logic [DATA_LEN-1:0] dev_in;
  logic                dma_ack;
  logic [DATA_LEN-1:0] dev_out;
  logic                end_flag;
  modport master (
    output rqst, rd_wr, start_addr, num_words, dev_ack, dev_in,
    input  dma_ack, dev_out, end_flag
  );
  modport slave (
    input  rqst, rd_wr, start_addr, num_words, dev_ack, dev_in,
    output dma_ack, dev_out, end_flag
  );
endinterface

// File: rtl/dma_dev_port_dev_buf.sv
// dev_buf: synchronous FIFO holding one complete transfer, with flush
module dev_buf #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] data,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  assign full = level[AW];
  assign empty = level == '0;
  assign head = mem[rp];
  // storage array, no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= data;
  end
  // pointers and occupancy; push+pop together leave level unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/dma_dev_port.sv
// dma_dev_port: device-side endpoint turning a command plus data stream into the DMA rqst/ack protocol
module dma_dev_port import dma_dev_port_pkg::*; #(
  parameter int ADD_LEN = ADD_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int BUF_AW = BUF_AW_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rd_wr,
  input  logic [ADD_LEN:0]    cmd_addr,
  input  logic [BUF_AW:0]     cmd_words,
  input  logic [DATA_LEN-1:0] src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [DATA_LEN-1:0] snk_data,
  output logic                snk_valid,
  input  logic                snk_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BUF_AW:0]     xfer_count,
  dma_dev_port_if.master      bus
);
  state_t state, state_n;
  logic [BUF_AW:0] words, cnt_n, level;
  logic overrun, overrun_n, fail, fail_n, done_n, err_n;
  logic push, pop, flush, full, empty, cmd_ok, xfer_n;
  logic [DATA_LEN-1:0] push_data, head;
  dev_buf #(.DW(DATA_LEN), .AW(BUF_AW)) u_buf (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .flush(flush),
    .data(push_data), .full(full), .empty(empty), .head(head), .level(level)
  );
  assign cmd_ok = cmd_words != '0 && cmd_words <= (BUF_AW+1)'(2**BUF_AW);
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign src_ready = state == FILL && !full;
  assign snk_valid = (state == XFER_RD || state == DRAIN) && !empty;
  assign snk_data = head;
  assign bus.dev_in = state == XFER_WR ? head : '0;
  assign bus.num_words = ADD_LEN'(words);
  assign xfer_n = state_n == XFER_WR || state_n == XFER_RD;
  assign flush = state != IDLE && state_n == IDLE;
  // next state, buffer strobes and completion verdict
  always_comb begin
    state_n = state;
    push = 1'b0;
    pop = 1'b0;
    push_data = bus.dev_out;
    cnt_n = xfer_count;
    overrun_n = overrun;
    fail_n = fail;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && !cmd_ok) err_n = 1'b1;
        if (cmd_valid && cmd_ok) begin
          state_n = cmd_rd_wr ? XFER_RD : FILL;
          cnt_n = '0;
          overrun_n = 1'b0;
          fail_n = 1'b0;
        end
      end
      FILL: begin
        push = src_valid && !full;
        push_data = src_data;
        if (push && level == words - 1'b1) state_n = XFER_WR;
      end
      XFER_WR: begin
        pop = bus.dma_ack && !empty;
        cnt_n = xfer_count + (BUF_AW+1)'(pop);
        overrun_n = overrun || (bus.dma_ack && empty);
        if (bus.end_flag) begin
          state_n = IDLE;
          err_n = cnt_n != words || overrun_n;
          done_n = !err_n;
        end
      end
      XFER_RD: begin
        push = bus.dma_ack && xfer_count < words;
        pop = snk_valid && snk_ready;
        cnt_n = xfer_count + (BUF_AW+1)'(push);
        overrun_n = overrun || (bus.dma_ack && !push);
        if (bus.end_flag) begin
          state_n = DRAIN;
          fail_n = cnt_n != words || overrun_n;
        end
      end
      DRAIN: begin
        pop = snk_valid && snk_ready;
        if (empty) begin
          state_n = IDLE;
          err_n = fail;
          done_n = !fail;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state, status pulses and registered DMA-facing request fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      words <= '0;
      xfer_count <= '0;
      overrun <= 1'b0;
      fail <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      bus.rqst <= 1'b0;
      bus.dev_ack <= 1'b0;
      bus.rd_wr <= 1'b0;
      bus.start_addr <= '0;
    end else begin
      state <= state_n;
      xfer_count <= cnt_n;
      overrun <= overrun_n;
      fail <= fail_n;
      done <= done_n;
      err <= err_n;
      bus.rqst <= xfer_n;
      bus.dev_ack <= xfer_n;
      if (state == IDLE && cmd_valid && cmd_ok) begin
        bus.rd_wr <= cmd_rd_wr;
        bus.start_addr <= cmd_addr & ~(ADD_LEN+1)'(1);
        words <= cmd_words;
      end
    end
  end
endmodule

// File: tb/tb_dma_dev_port.sv
// tb_dma_dev_port: directed stimulus with queued expectations checked by a negedge monitor
module tb_dma_dev_port;
  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rd_wr = 1'b0;
  logic [16:0] cmd_addr = '0;
  logic [4:0] cmd_words = '0, xfer_count;
  logic [15:0] src_data = '0, snk_data;
  logic src_valid = 1'b0, src_ready, snk_valid, snk_ready = 1'b0;
  logic busy, done, err;
  typedef struct {logic [1:0] code; logic [4:0] cnt;} ev_t;
  logic [15:0] q_dev[$], q_snk[$];
  ev_t q_ev[$];
  int checks = 0, errors = 0;

  dma_dev_port_if bus ();

  dma_dev_port dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd_wr(cmd_rd_wr), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .busy(busy), .done(done), .err(err), .xfer_count(xfer_count), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rd, input logic [16:0] a, input logic [4:0] w);
    cmd_valid = 1'b1;
    cmd_rd_wr = rd;
    cmd_addr = a;
    cmd_words = w;
    check("cmd_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_data = base + 16'(i);
      tick();
    end
    src_valid = 1'b0;
  endtask

  task automatic dma_word(input logic [15:0] d, input logic e);
    bus.dev_out = d;
    bus.dma_ack = 1'b1;
    bus.end_flag = e;
    tick();
    bus.dma_ack = 1'b0;
    bus.end_flag = 1'b0;
  endtask

  task automatic dma_end();
    bus.end_flag = 1'b1;
    tick();
    bus.end_flag = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (bus.dma_ack && bus.dev_ack && !bus.rd_wr) begin
      if (q_dev.size() == 0) begin
        checks++; errors++;
        $display("FAIL dev_in unexpected: got %0h", bus.dev_in);
      end else check("dev_in", 32'(bus.dev_in), 32'(q_dev.pop_front()));
    end
    if (snk_valid && snk_ready) begin
      if (q_snk.size() == 0) begin
        checks++; errors++;
        $display("FAIL snk_data unexpected: got %0h", snk_data);
      end else check("snk_data", 32'(snk_data), 32'(q_snk.pop_front()));
    end
    if (done || err) begin
      if (q_ev.size() == 0) begin
        checks++; errors++;
        $display("FAIL status unexpected: got err %0b done %0b", err, done);
      end else begin
        ev_t e;
        e = q_ev.pop_front();
        check("status {err,done}", 32'({err, done}), 32'(e.code));
        check("status xfer_count", 32'(xfer_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.dma_ack = 1'b0;
    bus.end_flag = 1'b0;
    bus.dev_out = '0;
    repeat (3) tick();
    check("rst rqst", 32'(bus.rqst), 0);
    check("rst dev_ack", 32'(bus.dev_ack), 0);
    check("rst rd_wr", 32'(bus.rd_wr), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done/err", 32'({done, err}), 0);
    check("rst snk/src", 32'({snk_valid, src_ready}), 0);
    check("rst start_addr", 32'(bus.start_addr), 0);
    check("rst num_words", 32'(bus.num_words), 0);
    check("rst xfer_count", 32'(xfer_count), 0);
    check("rst dev_in", 32'(bus.dev_in), 0);
    reset_n = 1'b1;
    tick();

    q_ev.push_back('{2'b10, 5'd0});
    send_cmd(1'b0, 17'h0, 5'd0);
    check("rej0 rqst", 32'(bus.rqst), 0);
    check("rej0 busy", 32'(busy), 0);
    tick();
    q_ev.push_back('{2'b10, 5'd0});
    send_cmd(1'b1, 17'h0, 5'd17);
    check("rej17 rqst", 32'(bus.rqst), 0);
    tick();
    check("rej17 rqst later", 32'(bus.rqst), 0);
    check("rej17 busy", 32'(busy), 0);

    for (int i = 0; i < 4; i++) q_dev.push_back(16'hA1 + 16'(i));
    q_ev.push_back('{2'b01, 5'd4});
    send_cmd(1'b0, 17'h0200, 5'd4);
    check("wr src_ready", 32'(src_ready), 1);
    check("wr rqst in fill", 32'(bus.rqst), 0);
    fill(16'hA1, 4);
    check("wr rqst", 32'(bus.rqst), 1);
    check("wr dev_ack", 32'(bus.dev_ack), 1);
    check("wr rd_wr", 32'(bus.rd_wr), 0);
    check("wr start_addr", 32'(bus.start_addr), 32'h200);
    check("wr num_words", 32'(bus.num_words), 4);
    for (int i = 0; i < 3; i++) dma_word(16'h0, 1'b0);
    dma_word(16'h0, 1'b1);
    check("wr rqst release", 32'(bus.rqst), 0);
    check("wr busy", 32'(busy), 0);
    tick();

    q_snk.push_back(16'h11); q_snk.push_back(16'h22); q_snk.push_back(16'h33);
    q_ev.push_back('{2'b01, 5'd3});
    send_cmd(1'b1, 17'h0301, 5'd3);
    check("rd rqst", 32'(bus.rqst), 1);
    check("rd rd_wr", 32'(bus.rd_wr), 1);
    check("rd start_addr", 32'(bus.start_addr), 32'h300);
    check("rd snk_valid pre", 32'(snk_valid), 0);
    dma_word(16'h11, 1'b0);
    check("rd snk_valid", 32'(snk_valid), 1);
    dma_word(16'h22, 1'b0);
    dma_word(16'h33, 1'b0);
    dma_end();
    check("rd rqst release", 32'(bus.rqst), 0);
    check("rd dev_ack drain", 32'(bus.dev_ack), 0);
    repeat (5) tick();
    check("rd busy stalled", 32'(busy), 1);
    snk_ready = 1'b1;
    wait_idle("rd idle");
    snk_ready = 1'b0;
    tick();

    q_snk.push_back(16'h55); q_snk.push_back(16'h66);
    q_ev.push_back('{2'b10, 5'd2});
    snk_ready = 1'b1;
    send_cmd(1'b1, 17'h0040, 5'd4);
    dma_word(16'h55, 1'b0);
    dma_word(16'h66, 1'b0);
    dma_end();
    wait_idle("early idle");
    snk_ready = 1'b0;
    tick();

    q_dev.push_back(16'hB1); q_dev.push_back(16'hB2);
    send_cmd(1'b0, 17'h0080, 5'd4);
    fill(16'hB1, 4);
    dma_word(16'h0, 1'b0);
    dma_word(16'h0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rst mid rqst", 32'(bus.rqst), 0);
    check("rst mid dev_ack", 32'(bus.dev_ack), 0);
    check("rst mid busy", 32'(busy), 0);
    check("rst mid xfer_count", 32'(xfer_count), 0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) q_snk.push_back(16'hC00 + 16'(i));
    q_ev.push_back('{2'b01, 5'd16});
    send_cmd(1'b1, 17'h1000, 5'd16);
    check("full num_words", 32'(bus.num_words), 16);
    check("full start_addr", 32'(bus.start_addr), 32'h1000);
    for (int i = 0; i < 16; i++) begin
      dma_word(16'hC00 + 16'(i), 1'b0);
      repeat (i % 3) tick();
    end
    dma_end();
    check("full rqst release", 32'(bus.rqst), 0);
    snk_ready = 1'b1;
    wait_idle("full idle");
    snk_ready = 1'b0;
    repeat (2) tick();

    check("q_dev drained", 32'(q_dev.size()), 0);
    check("q_snk drained", 32'(q_snk.size()), 0);
    check("q_ev drained", 32'(q_ev.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
